// File: rtl/bus_wait_responder.sv
// Memory-mapped 64x32 store that stalls the initiator for WAIT_CYCLES cycles per access.
// Define BUS_WAIT_RESPONDER_STATS_EN to map a completed-access counter onto word 63.
module bus_wait_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_4000,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  input  logic        we,
  input  logic        re,
  output logic [31:0] read_data,
  output logic        mem_busy
);

  // state    | meaning
  // S_IDLE   | waiting for a hit; a miss with a request clears read_data
  // S_WAIT   | counting down busy cycles; dropping re/we aborts
  // S_ACCESS | busy released; a latched write commits at the end of this cycle
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS} state_t;

  localparam logic [3:0] LOAD = 4'(WAIT_CYCLES - 1);

  state_t      state;
  logic [3:0]  count;
  logic [5:0]  idx_q;
  logic [31:0] wdata_q;
  logic        wr_q;
  logic [31:0] mem [64];

  logic        req;
  logic        hit;
  logic [5:0]  rd_idx;
  logic [31:0] rd_word;
  logic        unused_addr;

  assign req         = re | we;
  assign hit         = (address[31:8] == BASE_ADDR[31:8]) & req;
  assign mem_busy    = ~rst & (((state == S_IDLE) & hit) | (state == S_WAIT));
  assign unused_addr = ^address[1:0];

`ifdef BUS_WAIT_RESPONDER_STATS_EN
  logic [15:0] stat_count;

  // A write to word 63 clears instead of counting itself.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_count <= '0;
    end else if (state == S_ACCESS) begin
      if (wr_q && idx_q == 6'd63)
        stat_count <= '0;
      else if (stat_count != 16'hFFFF)
        stat_count <= stat_count + 16'd1;
    end
  end
`endif

  // With WAIT_CYCLES=1 the read is taken straight from IDLE, so use the live index there.
  always_comb begin
    rd_idx  = (state == S_IDLE) ? address[7:2] : idx_q;
    rd_word = mem[rd_idx];
`ifdef BUS_WAIT_RESPONDER_STATS_EN
    if (rd_idx == 6'd63)
      rd_word = {16'h0000, stat_count};
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst && state == S_ACCESS && wr_q)
      mem[idx_q] <= wdata_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      count     <= '0;
      idx_q     <= '0;
      wdata_q   <= '0;
      wr_q      <= 1'b0;
      read_data <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (hit) begin
            idx_q   <= address[7:2];
            wdata_q <= write_data;
            wr_q    <= we;
            count   <= LOAD;
            if (LOAD == 4'd0) begin
              state <= S_ACCESS;
              if (!we)
                read_data <= rd_word;
            end else begin
              state <= S_WAIT;
            end
          end else if (req) begin
            read_data <= '0;
          end
        end
        S_WAIT: begin
          if (!req) begin
            state <= S_IDLE;
            count <= '0;
          end else if (count <= 4'd1) begin
            count <= '0;
            state <= S_ACCESS;
            if (!wr_q)
              read_data <= rd_word;
          end else begin
            count <= count - 4'd1;
          end
        end
        S_ACCESS: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_wait_responder.sv
// Bench for bus_wait_responder: two instances (W=2 and W=4) checked against a word-array model.
module tb_bus_wait_responder;

  localparam logic [31:0] BASE = 32'h0000_4000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr_s [2];
  logic [31:0] wd_s   [2];
  logic        we_s   [2];
  logic        re_s   [2];
  logic [31:0] rd_s   [2];
  logic        busy_s [2];

  int vectors = 0;
  int miscompares = 0;

  // reference model: storage words, whether known, last read value
  logic [31:0] m_mem   [2][64];
  bit          m_known [2][64];
  logic [31:0] m_rd    [2];
  bit          m_rdk   [2];

  always #5 clk = ~clk;

  bus_wait_responder #(.BASE_ADDR(BASE), .WAIT_CYCLES(2)) dut0 (
    .clk(clk), .rst(rst), .address(addr_s[0]), .write_data(wd_s[0]),
    .we(we_s[0]), .re(re_s[0]), .read_data(rd_s[0]), .mem_busy(busy_s[0]));

  bus_wait_responder #(.BASE_ADDR(BASE), .WAIT_CYCLES(4)) dut1 (
    .clk(clk), .rst(rst), .address(addr_s[1]), .write_data(wd_s[1]),
    .we(we_s[1]), .re(re_s[1]), .read_data(rd_s[1]), .mem_busy(busy_s[1]));

  function automatic int wait_of(input int sel);
    return (sel == 1) ? 4 : 2;
  endfunction

  function automatic logic [15:0] busy_exp(input int sel);
    return 16'((1 << wait_of(sel)) - 1);
  endfunction

  // Drives one request and samples mem_busy in each cycle T0..T0+W, read_data at T0+W.
  task automatic run_access(input int sel, input logic [31:0] a, input logic [31:0] d,
                            input logic w, input logic r,
                            output logic [15:0] busy_bits, output logic [31:0] rd_obs);
    int wc;
    wc = wait_of(sel);
    busy_bits = '0;
    rd_obs = '0;
    @(negedge clk);
    addr_s[sel] = a; wd_s[sel] = d; we_s[sel] = w; re_s[sel] = r;
    for (int c = 0; c <= wc; c++) begin
      #1 busy_bits[c] = busy_s[sel];
      if (c == wc) rd_obs = rd_s[sel];
      else @(negedge clk);
    end
    if (w) begin
      m_mem[sel][a[7:2]] = d;
      m_known[sel][a[7:2]] = 1'b1;
    end else begin
      m_rd[sel]  = m_mem[sel][a[7:2]];
      m_rdk[sel] = m_known[sel][a[7:2]];
    end
  endtask

  task automatic go_idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      we_s[0] = 0; re_s[0] = 0; we_s[1] = 0; re_s[1] = 0;
    end
  endtask

  task automatic test_reset();
    #3;
    vectors++;
    if (busy_s[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_busy: got %b want 0", busy_s[0]);
    end
    vectors++;
    if (rd_s[0] !== 32'h0 || rd_s[1] !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_rdata: got %h/%h want 0", rd_s[0], rd_s[1]);
    end
    @(posedge clk); @(posedge clk); #2;
    re_s[0] = 0;
    rst = 1'b0;
    m_rd[0] = 0; m_rdk[0] = 1; m_rd[1] = 0; m_rdk[1] = 1;
  endtask

  task automatic test_write_read();
    logic [15:0] b; logic [31:0] r;
    run_access(0, BASE + 32'h10, 32'hDEAD_BEEF, 1, 0, b, r);
    vectors++;
    if (b !== busy_exp(0)) begin
      miscompares++;
      $display("FAIL wr_busy: got %b want %b", b, busy_exp(0));
    end
    vectors++;
    if (r !== 32'h0) begin
      miscompares++;
      $display("FAIL wr_rdata_held: got %h want 0", r);
    end
    run_access(0, BASE + 32'h10, 32'h0, 0, 1, b, r);
    vectors++;
    if (b !== busy_exp(0)) begin
      miscompares++;
      $display("FAIL rd_busy: got %b want %b", b, busy_exp(0));
    end
    vectors++;
    if (r !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL rd_data: got %h want deadbeef", r);
    end
    go_idle(1);
  endtask

  task automatic test_miss();
    logic [15:0] b; logic [31:0] r;
    run_access(0, BASE, 32'h1234_5678, 1, 0, b, r);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      addr_s[0] = 32'h0000_8000; wd_s[0] = 32'hFFFF_0000; we_s[0] = (k == 1); re_s[0] = (k == 0);
      #1;
      vectors++;
      if (busy_s[0] !== 1'b0) begin
        miscompares++;
        $display("FAIL miss_busy: got %b want 0", busy_s[0]);
      end
      @(negedge clk);
      vectors++;
      if (rd_s[0] !== 32'h0) begin
        miscompares++;
        $display("FAIL miss_rdata: got %h want 0", rd_s[0]);
      end
    end
    m_rd[0] = 0; m_rdk[0] = 1;
    run_access(0, BASE, 32'h0, 0, 1, b, r);
    vectors++;
    if (b !== busy_exp(0) || r !== 32'h1234_5678) begin
      miscompares++;
      $display("FAIL miss_storage: got %h busy %b want 12345678 busy %b", r, b, busy_exp(0));
    end
    go_idle(1);
  endtask

  task automatic test_both();
    logic [15:0] b; logic [31:0] r;
    run_access(0, BASE + 32'h08, 32'h0000_0005, 1, 1, b, r);
    vectors++;
    if (r !== 32'h1234_5678) begin
      miscompares++;
      $display("FAIL both_rdata_held: got %h want 12345678", r);
    end
    run_access(0, BASE + 32'h08, 32'h0, 0, 1, b, r);
    vectors++;
    if (r !== 32'h0000_0005) begin
      miscompares++;
      $display("FAIL both_written: got %h want 00000005", r);
    end
    go_idle(1);
  endtask

  task automatic test_abort();
    logic [15:0] b; logic [31:0] r;
    run_access(1, BASE + 32'h20, 32'h0BAD_F00D, 1, 0, b, r);
    run_access(1, BASE + 32'h24, 32'h600D_CAFE, 1, 0, b, r);
    run_access(1, BASE + 32'h20, 32'h0, 0, 1, b, r);
    vectors++;
    if (b !== busy_exp(1) || r !== 32'h0BAD_F00D) begin
      miscompares++;
      $display("FAIL w4_read: got %h busy %b want 0badf00d busy %b", r, b, busy_exp(1));
    end
    for (int k = 0; k < 2; k++) begin
      go_idle(1);
      @(negedge clk);
      addr_s[1] = BASE + (k == 0 ? 32'h24 : 32'h20); wd_s[1] = 32'hAAAA_5555;
      re_s[1] = (k == 0); we_s[1] = (k == 1);
      #1 b[0] = busy_s[1];
      @(negedge clk);
      #1 b[1] = busy_s[1];
      re_s[1] = 0; we_s[1] = 0;
      @(negedge clk);
      #1 b[2] = busy_s[1];
      vectors++;
      if (b[2:0] !== 3'b011) begin
        miscompares++;
        $display("FAIL abort_busy: got %b want 011", b[2:0]);
      end
      vectors++;
      if (rd_s[1] !== 32'h0BAD_F00D) begin
        miscompares++;
        $display("FAIL abort_rdata: got %h want 0badf00d", rd_s[1]);
      end
    end
    run_access(1, BASE + 32'h24, 32'h0, 0, 1, b, r);
    vectors++;
    if (b !== busy_exp(1) || r !== 32'h600D_CAFE) begin
      miscompares++;
      $display("FAIL after_abort_read: got %h busy %b want 600dcafe", r, b);
    end
    run_access(1, BASE + 32'h20, 32'h0, 0, 1, b, r);
    vectors++;
    if (r !== 32'h0BAD_F00D) begin
      miscompares++;
      $display("FAIL aborted_write: got %h want 0badf00d", r);
    end
    go_idle(1);
  endtask

  task automatic test_back_to_back();
    logic [15:0] b; logic [31:0] r;
    run_access(1, BASE + 32'h30, 32'hC0FF_EE01, 1, 0, b, r);
    run_access(1, BASE + 32'h30, 32'h0, 0, 1, b, r);
    vectors++;
    if (b !== busy_exp(1) || r !== 32'hC0FF_EE01) begin
      miscompares++;
      $display("FAIL b2b: got %h busy %b want c0ffee01 busy %b", r, b, busy_exp(1));
    end
    go_idle(1);
  endtask

  task automatic test_reset_midwrite();
    logic [15:0] b; logic [31:0] r;
    run_access(0, BASE + 32'h04, 32'h1111_1111, 1, 0, b, r);
    run_access(0, BASE + 32'h04, 32'h0, 0, 1, b, r);
    @(negedge clk);
    addr_s[0] = BASE + 32'h04; wd_s[0] = 32'h2222_2222; we_s[0] = 1; re_s[0] = 0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    vectors++;
    if (busy_s[0] !== 1'b0 || rd_s[0] !== 32'h0) begin
      miscompares++;
      $display("FAIL async_reset: busy %b rdata %h want 0/0", busy_s[0], rd_s[0]);
    end
    we_s[0] = 0;
    @(posedge clk); @(posedge clk); #2;
    rst = 1'b0;
    m_rd[0] = 0; m_rdk[0] = 1; m_rd[1] = 0; m_rdk[1] = 1;
    run_access(0, BASE + 32'h04, 32'h0, 0, 1, b, r);
    vectors++;
    if (b !== busy_exp(0) || r !== 32'h1111_1111) begin
      miscompares++;
      $display("FAIL reset_discard: got %h busy %b want 11111111", r, b);
    end
    go_idle(1);
  endtask

  task automatic test_word63();
    logic [15:0] b; logic [31:0] r;
`ifdef BUS_WAIT_RESPONDER_STATS_EN
    run_access(0, BASE + 32'hFC, 32'hFFFF_FFFF, 1, 0, b, r);
    run_access(0, BASE + 32'h40, 32'h7, 1, 0, b, r);
    run_access(0, BASE + 32'h44, 32'h8, 1, 0, b, r);
    run_access(0, BASE + 32'h40, 32'h0, 0, 1, b, r);
    run_access(0, BASE + 32'hFC, 32'h0, 0, 1, b, r);
    vectors++;
    if (r !== 32'h3) begin
      miscompares++;
      $display("FAIL stats_count: got %h want 00000003", r);
    end
    run_access(0, BASE + 32'hFC, 32'h1234, 1, 0, b, r);
    run_access(0, BASE + 32'hFC, 32'h0, 0, 1, b, r);
    vectors++;
    if (r !== 32'h0) begin
      miscompares++;
      $display("FAIL stats_clear: got %h want 00000000", r);
    end
    m_known[0][63] = 1'b0;
    m_rd[0] = r; m_rdk[0] = 1;
`else
    run_access(0, BASE + 32'hFC, 32'hA5A5_5A5A, 1, 0, b, r);
    run_access(0, BASE + 32'hFC, 32'h0, 0, 1, b, r);
    vectors++;
    if (r !== 32'hA5A5_5A5A) begin
      miscompares++;
      $display("FAIL word63_plain: got %h want a5a55a5a", r);
    end
`endif
    go_idle(1);
  endtask

  task automatic test_random();
    logic [15:0] b; logic [31:0] r, a, d;
    int k, op;
    for (int i = 0; i < 63; i++) begin
      d = $urandom;
      run_access(0, {BASE[31:8], 6'(i), 2'b00}, d, 1, 0, b, r);
      vectors++;
      if (b !== busy_exp(0)) begin
        miscompares++;
        $display("FAIL fill_busy: word %0d got %b want %b", i, b, busy_exp(0));
      end
    end
    for (int i = 0; i < 150; i++) begin
      k = $urandom_range(0, 99);
      if (k < 12) begin
        a = $urandom;
        if (a[31:8] == BASE[31:8]) a[31] = 1'b1;
        @(negedge clk);
        addr_s[0] = a; wd_s[0] = $urandom; op = $urandom_range(0, 2);
        we_s[0] = (op != 0); re_s[0] = (op != 1);
        #1;
        vectors++;
        if (busy_s[0] !== 1'b0) begin
          miscompares++;
          $display("FAIL rnd_miss_busy: addr %h got %b want 0", a, busy_s[0]);
        end
        @(negedge clk);
        we_s[0] = 0; re_s[0] = 0;
        vectors++;
        if (rd_s[0] !== 32'h0) begin
          miscompares++;
          $display("FAIL rnd_miss_rdata: addr %h got %h want 0", a, rd_s[0]);
        end
        m_rd[0] = 0; m_rdk[0] = 1;
      end else if (k < 22) begin
        go_idle(1);
      end else begin
        a = {BASE[31:8], 6'($urandom_range(0, 62)), 2'($urandom)};
        d = $urandom;
        op = $urandom_range(0, 2);
        run_access(0, a, d, op != 0, op != 1, b, r);
        vectors++;
        if (b !== busy_exp(0)) begin
          miscompares++;
          $display("FAIL rnd_busy: addr %h got %b want %b", a, b, busy_exp(0));
        end
        if (m_rdk[0]) begin
          vectors++;
          if (r !== m_rd[0]) begin
            miscompares++;
            $display("FAIL rnd_rdata: addr %h op %0d got %h want %h", a, op, r, m_rd[0]);
          end
        end
      end
    end
    go_idle(1);
  endtask

  initial begin
    for (int s = 0; s < 2; s++) begin
      addr_s[s] = BASE; wd_s[s] = '0; we_s[s] = 0; re_s[s] = 0;
      m_rd[s] = 0; m_rdk[s] = 1;
      for (int i = 0; i < 64; i++) begin
        m_mem[s][i] = '0; m_known[s][i] = 1'b0;
      end
    end
    re_s[0] = 1;
    test_reset();
    test_write_read();
    test_miss();
    test_both();
    test_abort();
    test_back_to_back();
    test_reset_midwrite();
    test_word63();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bus_wait_responder.md
BUS_WAIT_RESPONDER -- requirements
Module: bus_wait_responder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_4000, byte base of the 256-byte window; bits [7:0] are ignored.
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, busy cycles per access; legal range 1..15.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst  input  1  reset; asynchronous and active-high.
REQ-005 SHALL have port address  input  32  byte address from the bus initiator.
REQ-006 SHALL have port write_data  input  32  write word.
REQ-007 SHALL have port we  input  1  write request, held by the initiator while mem_busy=1.
REQ-008 SHALL have port re  input  1  read request, held by the initiator while mem_busy=1.
REQ-009 SHALL have port read_data  output  32  read word, registered.
REQ-010 SHALL have port mem_busy  output  1  stall to the initiator.

Function
REQ-011 SHALL contain 64x32 storage; word index = address[7:2]; address[1:0] ignored; full-word access only.
REQ-012 SHALL decode hit = (address[31:8]==BASE_ADDR[31:8]) & (re|we).
REQ-013 SHALL implement FSM IDLE, WAIT, ACCESS; IDLE->WAIT on hit; WAIT->ACCESS when the counter reaches 0; ACCESS->IDLE unconditionally.
REQ-014 SHALL latch address, write_data and the operation on the hit cycle T0, and load the counter with WAIT_CYCLES-1.
REQ-015 SHALL drive mem_busy combinationally high in IDLE on hit, high throughout WAIT, and low in ACCESS; net result: high for cycles T0..T0+W-1 and low at T0+W.
REQ-016 SHALL, on a read, load read_data from storage at the edge ending cycle T0+W-1, so read_data is valid during T0+W and held until the next read completes or a miss occurs.
REQ-017 SHALL, on a write, commit storage at the edge ending cycle T0+W.
REQ-018 SHALL treat re&we together as a write; read_data is unchanged in that case.
REQ-019 SHALL, on a miss in IDLE, keep mem_busy=0, leave state and storage unchanged, and drive read_data to 0 from the next edge.
REQ-020 SHALL, if re and we both drop while in WAIT (abort), return to IDLE on the next edge with no write, no read_data update, and mem_busy=0.
REQ-021 SHALL ignore address and write_data changes during WAIT; only the values latched at T0 are used.
REQ-022 SHALL treat a request present in the cycle after ACCESS as a new transaction; back-to-back accesses therefore take W+1 cycles each.

Reset
REQ-023 SHALL, while rst=1, force state=IDLE, counter=0, mem_busy=0 and read_data=0 immediately, regardless of clk.
REQ-024 SHALL NOT reset storage contents; a write in progress when rst asserts SHALL be discarded.
REQ-025 SHALL accept the first request on the first rising edge after rst deasserts.

Configuration
REQ-026 SHALL support macro BUS_WAIT_RESPONDER_STATS_EN; when defined, word 63 is a 16-bit saturating counter of completed (non-aborted) accesses, read zero-extended; any write to word 63 clears it; the access that reads word 63 is not included in the value returned.
REQ-027 SHALL, without BUS_WAIT_RESPONDER_STATS_EN, treat word 63 as ordinary storage and include no counter logic.

Verification
REQ-028 SHALL cover: W=2, write 0xDEADBEEF to BASE+0x10 then read it -> mem_busy high for 2 cycles per access; read_data=0xDEADBEEF in the 3rd cycle of the read.
REQ-029 SHALL cover: read of 0x0000_8000 (miss) -> mem_busy stays 0; read_data=0 after 1 edge; storage unchanged.
REQ-030 SHALL cover: W=4, re dropped in the 2nd busy cycle -> IDLE next edge; no read_data update; a following read completes normally.
REQ-031 SHALL cover: rst asserted mid-write at BASE+0x04 (old value 0x11111111) -> mem_busy=0 asynchronously; a re-read after reset returns 0x11111111.
REQ-032 SHALL cover: re=we=1 to BASE+0x08 with 0x00000005 -> treated as a write; the next read returns 0x00000005.
REQ-033 SHALL cover, with STATS_EN: 3 completed accesses then a read of word 63 -> 0x00000003; a write to word 63 followed by a read -> 0x00000000.
